// File: rtl/sftreg_dly_pkg.sv
// Shared constants and the delay-clamp helper for the programmable strobe delay line.
package sftreg_dly_pkg;

  localparam int SFT_MAX_DEPTH = 8;

  // Requested delays of 0 act as 1; anything beyond the line length saturates.
  function automatic logic [31:0] sft_clamp(input logic [31:0] req, input logic [31:0] max_dly);
    logic [31:0] res;
    res = req;
    if (req == 32'd0) begin
      res = 32'd1;
    end else if (req > max_dly) begin
      res = max_dly;
    end
    return res;
  endfunction

endpackage

// File: rtl/sftreg_stage.sv
// One {vld, dat} stage of the delay line; clear beats enable, holds when disabled.
module sftreg_stage #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vld <= 1'b0;
      o_dat <= '0;
    end else if (i_clr) begin
      o_vld <= 1'b0;
    end else if (i_en) begin
      o_vld <= i_vld;
      o_dat <= i_dat;
    end
  end

endmodule

// File: rtl/sftreg_dly.sv
// Runtime-programmable strobe+payload delay line (1..MAX_DEPTH cycles, +1 per stalled cycle).
// Backpressure: o_rdy drops while draining in-flight strobes ahead of a delay change.
module sftreg_dly
  import sftreg_dly_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_DEPTH = SFT_MAX_DEPTH,
  parameter int DEF_DLY   = 1,
  parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [DW-1:0]    i_dly,
  input  logic             i_dly_we,
  output logic             o_we,
  output logic [WIDTH-1:0] o_data,
  output logic             o_rdy,
  output logic [DW-1:0]    o_cnt,
  output logic [DW-1:0]    o_dly
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } st_e;

  st_e st_q, st_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [DW-1:0] pend_q, pend_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] req_dly;

  logic             acc_vld;
  logic             emit_vld;
  logic             tap_vld;
  logic [WIDTH-1:0] tap_dat;

  logic [MAX_DEPTH-1:0] stg_vld;
  logic [MAX_DEPTH-1:0] stg_in_vld;
  logic [WIDTH-1:0]     stg_dat    [MAX_DEPTH];
  logic [WIDTH-1:0]     stg_in_dat [MAX_DEPTH];

  assign req_dly  = DW'(sft_clamp({{(32-DW){1'b0}}, i_dly}, 32'(MAX_DEPTH)));
  assign o_rdy    = (st_q == ST_RUN);
  assign acc_vld  = i_we & o_rdy & ~i_stall & ~i_flush;
  assign emit_vld = tap_vld & ~i_stall;

  assign stg_in_vld[0] = acc_vld;
  assign stg_in_dat[0] = i_data;

  // Stages past the tap load empty slots, so a later delay increase never exposes stale strobes.
  for (genvar k = 1; k < MAX_DEPTH; k++) begin : g_link
    assign stg_in_vld[k] = stg_vld[k-1] & (DW'(k) < dly_q);
    assign stg_in_dat[k] = stg_dat[k-1];
  end

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    sftreg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (~i_stall),
      .i_clr (i_flush),
      .i_vld (stg_in_vld[k]),
      .i_dat (stg_in_dat[k]),
      .o_vld (stg_vld[k]),
      .o_dat (stg_dat[k])
    );
  end

  always_comb begin
    tap_vld = 1'b0;
    tap_dat = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (DW'(k) == (dly_q - DW'(1))) begin
        tap_vld = stg_vld[k];
        tap_dat = stg_dat[k];
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    dly_d  = dly_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (i_flush) begin
      cnt_d = '0;
      st_d  = ST_RUN;
      if (st_q == ST_DRAIN) begin
        dly_d = pend_q;
      end
    end else if (!i_stall) begin
      cnt_d = cnt_q + DW'(acc_vld) - DW'(emit_vld);
      unique case (st_q)
        ST_RUN: begin
          if (i_dly_we) begin
            if ((cnt_q == '0) && !acc_vld) begin
              dly_d = req_dly;
            end else begin
              pend_d = req_dly;
              st_d   = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (i_dly_we) begin
            pend_d = req_dly;
          end
          // Leave DRAIN on the edge that retires the last strobe so o_rdy rises right after it.
          if (cnt_d == '0) begin
            dly_d = i_dly_we ? req_dly : pend_q;
            st_d  = ST_RUN;
          end
        end
        default: st_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q   <= ST_RUN;
      dly_q  <= DW'(DEF_DLY);
      pend_q <= DW'(DEF_DLY);
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      dly_q  <= dly_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_we   = emit_vld;
  assign o_data = tap_dat;
  assign o_cnt  = cnt_q;
  assign o_dly  = dly_q;

endmodule
